// File: rtl/note_to_dds_if.sv
// Note-to-increment bus: the MIDI note goes in, the registered DDS phase
// increment comes back one clock later. No handshake; both sides run every cycle.
interface note_to_dds_if;
    logic [6:0]  note;
    logic [31:0] adder;

    // Note source (MIDI / pitch-bend logic) drives the note and reads the increment.
    modport master (output note, input adder);

    // Converter consumes the note and presents the increment.
    modport slave  (input note, output adder);
endinterface

// File: rtl/note_to_dds.sv
// MIDI note -> 32-bit DDS phase increment for a 50 MHz, 32-bit accumulator,
// tuned to A4 (note 69) = 440 Hz.
//
// Built as a registered lookup. A 12-entry table holds the increments for
// notes 120..131, the top octave. Lower octaves are reached by a logical right
// shift of (10 - octave). The shift truncates, which keeps every octave step an
// exact doubling plus at most one LSB.
//
// Latency is one clock and a new note is accepted every cycle.
module note_to_dds (
    input  logic          clk,
    input  logic          rst_n,
    note_to_dds_if.slave  bus
);

    logic [3:0]  oct;
    logic [6:0]  rem;
    logic [20:0] base;
    logic [3:0]  shift;
    logic [31:0] adder_next;
    logic [31:0] adder_q;

    // Split the note into octave (0..10) and semitone (0..11).
    // This uses a chain of ten compare/subtract-by-12 steps, so no divider is needed.
    always_comb begin
        oct = 4'd0;
        rem = bus.note;
        for (int k = 0; k < 10; k++) begin
            if (rem >= 7'd12) begin
                rem = rem - 7'd12;
                oct = oct + 4'd1;
            end
        end
    end

    // Top-octave increments: round(440 * 2^((120+idx-69)/12) * 2^32 / 50e6).
    // Entries 8..11 are only ever reached from notes below 120.
    always_comb begin
        base = 21'd0;
        case (rem)
            7'd0:    base = 21'd719151;   // C   8372.018 Hz
            7'd1:    base = 21'd761914;   // C#  8869.844 Hz
            7'd2:    base = 21'd807220;   // D   9397.273 Hz
            7'd3:    base = 21'd855219;   // D#  9956.063 Hz
            7'd4:    base = 21'd906073;   // E  10548.082 Hz
            7'd5:    base = 21'd959951;   // F  11175.303 Hz
            7'd6:    base = 21'd1017033;  // F# 11839.822 Hz
            7'd7:    base = 21'd1077509;  // G  12543.854 Hz
            7'd8:    base = 21'd1141581;  // G# 13289.750 Hz
            7'd9:    base = 21'd1209463;  // A  14080.000 Hz
            7'd10:   base = 21'd1281381;  // A# 14917.240 Hz
            7'd11:   base = 21'd1357576;  // B  15804.266 Hz
            default: base = 21'd0;
        endcase
    end

    // Drop down from the top octave by a truncating logical shift.
    // The upper 11 bits of the result are always zero.
    always_comb begin
        shift      = 4'd10 - oct;
        adder_next = {11'd0, base} >> shift;
    end

    // Output register with synchronous active-low reset. Reset wins over the lookup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adder_q <= 32'd0;
        end else begin
            adder_q <= adder_next;
        end
    end

    assign bus.adder = adder_q;

endmodule

// File: tb/tb_note_to_dds.sv
// Scoreboard bench for note_to_dds.
// The stimulus process pushes the expected increment for each cycle it drives.
// The monitor pops and compares one cycle later.
module tb_note_to_dds;

    logic clk;
    logic rst_n;

    note_to_dds_if nif ();

    note_to_dds dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (nif.slave)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        int          note;
        bit          sweep;
        string       name;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] observed [0:127];

    // Golden model evaluated straight from the tuning formula.
    function automatic logic [31:0] model(input int n);
        int     oct;
        int     idx;
        real    f;
        longint b;
        oct = n / 12;
        idx = n % 12;
        f   = 440.0 * (2.0 ** ((120.0 + idx - 69.0) / 12.0)) * 4294967296.0 / 50.0e6;
        b   = longint'($rtoi(f + 0.5));
        return 32'(b >> (10 - oct));
    endfunction

    // Drive one cycle of stimulus and record what the DUT must present after the next edge.
    task automatic drive(input int n, input logic rst, input logic [31:0] exp,
                         input string name, input bit sweep);
        sb_entry_t e;
        @(negedge clk);
        nif.note = 7'(n);
        rst_n    = rst;
        e.exp    = exp;
        e.note   = n;
        e.sweep  = sweep;
        e.name   = name;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the registered output just after every rising edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (nif.adder !== e.exp) begin
                    errors++;
                    $display("FAIL %s note=%0d: adder=%0d expected=%0d",
                             e.name, e.note, nif.adder, e.exp);
                end
                if (e.sweep) observed[e.note] = nif.adder;
            end
        end
    end

    initial begin
        int budget;
        rst_n    = 1'b0;
        nif.note = 7'd69;

        // Reset held for three edges with note 69, then released.
        for (int i = 0; i < 3; i++) drive(69, 1'b0, 32'd0, "reset_hold", 1'b0);
        drive(69, 1'b1, 32'd37795, "reset_release", 1'b0);

        // Spot values
        drive(0,   1'b1, 32'd702,     "spot_0",   1'b0);
        drive(60,  1'b1, 32'd22473,   "spot_60",  1'b0);
        drive(69,  1'b1, 32'd37795,   "spot_69",  1'b0);
        drive(120, 1'b1, 32'd719151,  "spot_120", 1'b0);
        drive(127, 1'b1, 32'd1077509, "spot_127", 1'b0);

        // Back-to-back changes, one per clock
        drive(60,  1'b1, 32'd22473,   "b2b_60",  1'b0);
        drive(61,  1'b1, 32'd23809,   "b2b_61",  1'b0);
        drive(127, 1'b1, 32'd1077509, "b2b_127", 1'b0);
        drive(0,   1'b1, 32'd702,     "b2b_0",   1'b0);

        // Full sweep against the formula
        for (int n = 0; n < 128; n++) drive(n, 1'b1, model(n), "sweep", 1'b1);

        // Mid-stream reset for a single edge while notes keep changing
        drive(30, 1'b1, model(30), "mid_pre",    1'b0);
        drive(31, 1'b1, model(31), "mid_pre",    1'b0);
        drive(32, 1'b0, 32'd0,     "mid_reset",  1'b0);
        drive(33, 1'b1, model(33), "mid_resume", 1'b0);
        drive(34, 1'b1, model(34), "mid_resume", 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        // Properties over the observed sweep results
        for (int n = 0; n < 127; n++) begin
            checks++;
            if (!(observed[n+1] > observed[n])) begin
                errors++;
                $display("FAIL monotonic n=%0d: adder(n)=%0d adder(n+1)=%0d expected greater",
                         n, observed[n], observed[n+1]);
            end
        end
        for (int n = 0; n < 116; n++) begin
            checks++;
            if (observed[n+12] !== {observed[n][30:0], 1'b0} &&
                observed[n+12] !== {observed[n][30:0], 1'b1}) begin
                errors++;
                $display("FAIL octave n=%0d: adder(n+12)=%0d expected %0d or %0d",
                         n, observed[n+12], 2*observed[n], 2*observed[n]+1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
